// File: rtl/flash_loader_pkg.sv
// Shared types and helpers for the flash-to-sample-RAM loader.
// Optional checksum output: define FLASH_LOADER_CHECKSUM_EN.
package flash_loader_pkg;

    typedef enum logic [2:0] {IDLE, REQ, WAIT, WRITE, DONE} loader_state_e;

    localparam int unsigned FLASH_WORD_W = 32;

    function automatic int unsigned spw(input int unsigned sample_w);
        return FLASH_WORD_W / sample_w;
    endfunction

endpackage

// File: rtl/flash_sample_loader_if.sv
// Control, Avalon-MM flash read port and sample RAM write port of the loader.
// The checksum signal exists only when FLASH_LOADER_CHECKSUM_EN is defined.
interface flash_sample_loader_if
    import flash_loader_pkg::*;
#(
    parameter int unsigned FLASH_AW = 23,
    parameter int unsigned MEM_AW   = 8,
    parameter int unsigned SAMPLE_W = 16
);
    logic                    start;
    logic                    busy;
    logic                    done;
    logic                    flash_mem_read;
    logic [FLASH_AW-1:0]     flash_mem_address;
    logic [3:0]              flash_mem_byteenable;
    logic                    flash_mem_waitrequest;
    logic [FLASH_WORD_W-1:0] flash_mem_readdata;
    logic                    flash_mem_readdatavalid;
    logic [MEM_AW-1:0]       mem_address;
    logic [SAMPLE_W-1:0]     mem_data;
    logic                    mem_wren;

`ifdef FLASH_LOADER_CHECKSUM_EN
    logic [31:0]             checksum;

    modport master (
        input  start, flash_mem_waitrequest, flash_mem_readdata, flash_mem_readdatavalid,
        output busy, done, flash_mem_read, flash_mem_address, flash_mem_byteenable,
        output mem_address, mem_data, mem_wren, checksum
    );
    modport slave (
        output start, flash_mem_waitrequest, flash_mem_readdata, flash_mem_readdatavalid,
        input  busy, done, flash_mem_read, flash_mem_address, flash_mem_byteenable,
        input  mem_address, mem_data, mem_wren, checksum
    );
`else
    modport master (
        input  start, flash_mem_waitrequest, flash_mem_readdata, flash_mem_readdatavalid,
        output busy, done, flash_mem_read, flash_mem_address, flash_mem_byteenable,
        output mem_address, mem_data, mem_wren
    );
    modport slave (
        output start, flash_mem_waitrequest, flash_mem_readdata, flash_mem_readdatavalid,
        input  busy, done, flash_mem_read, flash_mem_address, flash_mem_byteenable,
        input  mem_address, mem_data, mem_wren
    );
`endif

endinterface

// File: rtl/sample_unpacker.sv
// Holds one flash word and steps through its samples, lowest bits first.
module sample_unpacker
    import flash_loader_pkg::*;
#(
    parameter int unsigned SAMPLE_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_i,
    input  logic [FLASH_WORD_W-1:0] word_i,
    input  logic                    advance_i,
    output logic [SAMPLE_W-1:0]     sample_o,
    output logic                    last_o
);
    localparam int unsigned SPW  = spw(SAMPLE_W);
    localparam int unsigned IdxW = (SPW > 1) ? $clog2(SPW) : 1;

    logic [FLASH_WORD_W-1:0] hold_q, hold_d;
    logic [IdxW-1:0]         idx_q, idx_d;

    assign sample_o = hold_q[idx_q*SAMPLE_W +: SAMPLE_W];
    assign last_o   = (idx_q == IdxW'(SPW - 1));

    always_comb begin
        hold_d = hold_q;
        idx_d  = idx_q;
        if (load_i) begin
            hold_d = word_i;
            idx_d  = '0;
        end else if (advance_i) begin
            // Wrap keeps the slice in range when a word holds a single sample.
            idx_d = last_o ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_q <= '0;
            idx_q  <= '0;
        end else begin
            hold_q <= hold_d;
            idx_q  <= idx_d;
        end
    end

endmodule

// File: rtl/flash_sample_loader.sv
// Copies NUM_WORDS flash words into sample RAM, one sample per write cycle.
// Define FLASH_LOADER_CHECKSUM_EN to add a 32-bit running sum of written samples.
module flash_sample_loader
    import flash_loader_pkg::*;
#(
    parameter int unsigned NUM_WORDS  = 128,
    parameter int unsigned FLASH_AW   = 23,
    parameter int unsigned FLASH_BASE = 0,
    parameter int unsigned MEM_AW     = 8,
    parameter int unsigned MEM_BASE   = 0,
    parameter int unsigned SAMPLE_W   = 16
) (
    input logic                   clk,
    input logic                   rst_n,
    flash_sample_loader_if.master bus
);
    localparam int unsigned CntW = $clog2(NUM_WORDS + 1);

    loader_state_e       state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                busy_q, busy_d, done_q, done_d;
    logic                read_q, read_d, wren_q, wren_d;
    logic [FLASH_AW-1:0] faddr_q, faddr_d;
    logic [MEM_AW-1:0]   maddr_q, maddr_d;
    logic [SAMPLE_W-1:0] mdata_q, mdata_d;
    logic                load, advance, last, accept, more;
    logic [SAMPLE_W-1:0] sample;

    // busy_q is still high during the first DONE cycle, so start is only taken after it.
    assign accept = bus.start && !busy_q && (state_q == IDLE || state_q == DONE);
    assign more   = (32'(cnt_q) + 32'd1) < NUM_WORDS;

    sample_unpacker #(
        .SAMPLE_W (SAMPLE_W)
    ) u_unpacker (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (load),
        .word_i    (bus.flash_mem_readdata),
        .advance_i (advance),
        .sample_o  (sample),
        .last_o    (last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            read_q  <= 1'b0;
            wren_q  <= 1'b0;
            faddr_q <= FLASH_AW'(FLASH_BASE);
            maddr_q <= MEM_AW'(MEM_BASE);
            mdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            read_q  <= read_d;
            wren_q  <= wren_d;
            faddr_q <= faddr_d;
            maddr_q <= maddr_d;
            mdata_q <= mdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = REQ;
            REQ:     if (!bus.flash_mem_waitrequest) state_d = WAIT;
            WAIT:    if (bus.flash_mem_readdatavalid) state_d = WRITE;
            WRITE:   if (last) state_d = more ? REQ : DONE;
            DONE:    if (accept) state_d = REQ;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        read_d  = read_q;
        faddr_d = faddr_q;
        // Address advances in the cycle after each presented write.
        maddr_d = wren_q ? maddr_q + 1'b1 : maddr_q;
        mdata_d = mdata_q;
        wren_d  = 1'b0;
        busy_d  = busy_q;
        done_d  = done_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        advance = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE) begin
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end
                if (accept) begin
                    read_d  = 1'b1;
                    faddr_d = FLASH_AW'(FLASH_BASE);
                    maddr_d = MEM_AW'(MEM_BASE);
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end
            end
            REQ:   if (!bus.flash_mem_waitrequest) read_d = 1'b0;
            WAIT:  load = bus.flash_mem_readdatavalid;
            WRITE: begin
                wren_d  = 1'b1;
                mdata_d = sample;
                advance = 1'b1;
                if (last && more) begin
                    cnt_d   = cnt_q + 1'b1;
                    faddr_d = faddr_q + 1'b1;
                    read_d  = 1'b1;
                end
            end
            default: ;
        endcase
    end

`ifdef FLASH_LOADER_CHECKSUM_EN
    logic [31:0] cks_q, cks_d;

    always_comb begin
        cks_d = cks_q;
        if (accept) begin
            cks_d = '0;
        end else if (state_q == WRITE) begin
            cks_d = cks_q + 32'(sample);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cks_q <= '0;
        end else begin
            cks_q <= cks_d;
        end
    end

    assign bus.checksum = cks_q;
`endif

    assign bus.busy                 = busy_q;
    assign bus.done                 = done_q;
    assign bus.flash_mem_read       = read_q;
    assign bus.flash_mem_address    = faddr_q;
    assign bus.flash_mem_byteenable = 4'b1111;
    assign bus.mem_address          = maddr_q;
    assign bus.mem_data             = mdata_q;
    assign bus.mem_wren             = wren_q;

endmodule
